solution_player: RTL

//  Downstream of the solver core. Captures the solver's move stream (face, turn) into a

---
 rtl/solution_player_pkg.sv | 45 ++++
 rtl/solution_player_seg_scan.sv | 54 +++++
 rtl/solution_player.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/solution_player_pkg.sv
// Shared definitions for the solution player: FSM states, move codes,
// the buffered move record and the blank display digit.
package solution_player_pkg;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_PLAY = 2'd1,
    ST_END  = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    FACE_U = 3'd0,
    FACE_D = 3'd1,
    FACE_F = 3'd2,
    FACE_B = 3'd3,
    FACE_L = 3'd4,
    FACE_R = 3'd5
  } face_t;

  typedef enum logic [1:0] {
    TURN_NONE = 2'd0,
    TURN_CW   = 2'd1,
    TURN_HALF = 2'd2,
    TURN_CCW  = 2'd3
  } turn_t;

  // One buffer entry: 5 bits, face in the upper bits.
  typedef struct packed {
    face_t face;
    turn_t turn;
  } move_t;

  localparam logic [3:0] DIGIT_BLANK = 4'hF;

  // Position of the set bit in a one-hot digit select.
  function automatic logic [1:0] onehot_idx(input logic [3:0] oh);
    logic [1:0] r;
    r = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (oh[i]) r = i[1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/solution_player_seg_scan.sv
// Display scanner for the 4-digit multiplexed display.
//  clk, rst            : clock, synchronous active-high reset
//  digit0..digit3      : digit values (0 = rightmost slot)
//  cs_out              : one-hot digit select, active-high, rotates left
//  data_disp           : {6'h00, selected digit}, registered together with cs_out
module solution_player_seg_scan
  import solution_player_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] digit0,
  input  logic [3:0] digit1,
  input  logic [3:0] digit2,
  input  logic [3:0] digit3,
  output logic [3:0] cs_out,
  output logic [9:0] data_disp
);

  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CW-1:0] scan_cnt;
  logic          wrap;
  logic [3:0]    cs_nxt;
  logic [3:0]    digit_sel;

  assign wrap = (scan_cnt == CW'(SCAN_DIV - 1));

  // Select the digit for the slot that will be active next cycle so that
  // cs_out and data_disp always change on the same edge.
  always_comb begin
    cs_nxt = wrap ? {cs_out[2:0], cs_out[3]} : cs_out;
    unique case (onehot_idx(cs_nxt))
      2'd0:    digit_sel = digit0;
      2'd1:    digit_sel = digit1;
      2'd2:    digit_sel = digit2;
      default: digit_sel = digit3;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt  <= '0;
      cs_out    <= 4'b0001;
      data_disp <= '0;
    end else begin
      scan_cnt  <= wrap ? '0 : scan_cnt + CW'(1);
      cs_out    <= cs_nxt;
      data_disp <= {6'h00, digit_sel};
    end
  end

endmodule

// File: rtl/solution_player.sv
// Solution player: buffers the solver's move stream, then steps through it one
// move per "next" press and shows the current step on the multiplexed display.
//  clk, rst              : clock, synchronous active-high reset
//  mv_valid/face/turn    : move record from the solver (turn 0 is illegal, dropped)
//  mv_done               : solver finished pulse
//  next_btn, restart_btn : synchronised button levels, rising edge acts
//  ready                 : moves are being accepted (LOAD and buffer not full)
//  playing, last         : state is PLAY / END
//  overflow              : sticky, a legal move was dropped for lack of space
//  cs_out, data_disp     : display digit select and digit value
module solution_player
  import solution_player_pkg::*;
#(
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mv_valid,
  input  logic [2:0] mv_face,
  input  logic [1:0] mv_turn,
  input  logic       mv_done,
  input  logic       next_btn,
  input  logic       restart_btn,
  output logic       ready,
  output logic       playing,
  output logic       last,
  output logic       overflow,
  output logic [3:0] cs_out,
  output logic [9:0] data_disp
);

  localparam int unsigned CNTW = AW + 1;

  state_t          state;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   idx;
  logic [CNTW-1:0] count;
  logic [CNTW-1:0] count_after;
  logic [3:0]      step_ones;
  logic [3:0]      step_tens;
  logic            next_q;
  logic            restart_q;
  logic            next_edge;
  logic            restart_edge;
  logic            legal_mv;
  logic            store;
  logic            drop_full;
  move_t           wr_move;
  move_t           rd_data;
  move_t           mem [DEPTH];
  logic            blank;
  logic [3:0]      digit0, digit1, digit2, digit3;

  assign next_edge    = next_btn & ~next_q;
  assign restart_edge = restart_btn & ~restart_q;

  always_comb begin
    legal_mv     = (state == ST_LOAD) && mv_valid && (mv_turn != TURN_NONE);
    store        = legal_mv && (count < CNTW'(DEPTH));
    drop_full    = legal_mv && !(count < CNTW'(DEPTH));
    // A move arriving with mv_done counts toward the empty/non-empty decision.
    count_after  = count + CNTW'(store);
    wr_move.face = face_t'(mv_face);
    wr_move.turn = turn_t'(mv_turn);
  end

  // Move buffer: no reset so it maps onto block RAM; registered read.
  always_ff @(posedge clk) begin
    if (store) mem[wr_ptr] <= wr_move;
    rd_data <= mem[idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_LOAD;
      wr_ptr    <= '0;
      count     <= '0;
      idx       <= '0;
      step_ones <= 4'd1;
      step_tens <= 4'd0;
      overflow  <= 1'b0;
      ready     <= 1'b1;
      playing   <= 1'b0;
      last      <= 1'b0;
      next_q    <= 1'b0;
      restart_q <= 1'b0;
    end else begin
      next_q    <= next_btn;
      restart_q <= restart_btn;
      unique case (state)
        ST_LOAD: begin
          if (store) begin
            wr_ptr <= wr_ptr + AW'(1);
            count  <= count_after;
          end
          if (drop_full) overflow <= 1'b1;
          if (mv_done) begin
            ready <= 1'b0;
            if (count_after != '0) begin
              state   <= ST_PLAY;
              playing <= 1'b1;
            end else begin
              state <= ST_END;
              last  <= 1'b1;
            end
          end else begin
            ready <= (count_after < CNTW'(DEPTH));
          end
        end
        ST_PLAY: begin
          // Restart takes priority over next when both rise together.
          if (restart_edge) begin
            idx       <= '0;
            step_ones <= 4'd1;
            step_tens <= 4'd0;
          end else if (next_edge) begin
            if ((CNTW'(idx) + CNTW'(1)) < count) begin
              idx <= idx + AW'(1);
              if (step_ones == 4'd9) begin
                step_ones <= 4'd0;
                step_tens <= step_tens + 4'd1;
              end else begin
                step_ones <= step_ones + 4'd1;
              end
            end else begin
              state   <= ST_END;
              playing <= 1'b0;
              last    <= 1'b1;
            end
          end
        end
        ST_END: begin
          if (restart_edge && (count != '0)) begin
            state     <= ST_PLAY;
            playing   <= 1'b1;
            last      <= 1'b0;
            idx       <= '0;
            step_ones <= 4'd1;
            step_tens <= 4'd0;
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

  // Nothing meaningful to show while loading or after an empty solution.
  always_comb begin
    blank  = (state == ST_LOAD) || ((state == ST_END) && (count == '0));
    digit0 = blank ? DIGIT_BLANK : {2'b00, rd_data.turn};
    digit1 = blank ? DIGIT_BLANK : {1'b0, rd_data.face};
    digit2 = blank ? 4'd0 : step_ones;
    digit3 = blank ? 4'd0 : step_tens;
  end

  solution_player_seg_scan #(
    .SCAN_DIV(SCAN_DIV)
  ) u_seg_scan (
    .clk      (clk),
    .rst      (rst),
    .digit0   (digit0),
    .digit1   (digit1),
    .digit2   (digit2),
    .digit3   (digit3),
    .cs_out   (cs_out),
    .data_disp(data_disp)
  );

endmodule
